// File: rtl/addseq_if.sv
// Operand/result handshake bundle for addseq_ctrl.
//   slave  : the sequencer side (consumes operands, produces the result)
//   master : the upstream/downstream side (drives operands, accepts the result)
// Signals: in_valid/in_ready, a, b, cin, op | out_valid/out_ready, sum, cout, ovf
interface addseq_if #(
    parameter int unsigned NBYTES = 4
);
    localparam int unsigned W = 8 * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/addseq_ctrl.sv
// Multi-precision add sequencer: accepts an 8*NBYTES-bit operand pair, steps a
// shared 8-bit hybrid adder LSB byte to MSB byte chaining the carry, and returns
// sum, carry-out and signed overflow over a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), bus (addseq_if.slave).
// Optional feature: define ADDSEQ_SUB_EN to honour op=1 as subtract (a - b).

// 8-bit adder: ripple low nibble, carry-select high nibble.
module hybridadder8_struct (
    output logic [7:0] S,
    output logic       C8,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic       C0
);
    logic [4:0] lc;
    logic [4:0] hc0;
    logic [4:0] hc1;
    logic [3:0] hs0;
    logic [3:0] hs1;

    always_comb begin
        lc  = '0;
        hc0 = '0;
        hc1 = '0;
        hs0 = '0;
        hs1 = '0;
        S   = '0;
        lc[0]  = C0;
        hc1[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            S[i]       = X[i] ^ Y[i] ^ lc[i];
            lc[i+1]    = (X[i] & Y[i]) | (lc[i] & (X[i] ^ Y[i]));
            hs0[i]     = X[i+4] ^ Y[i+4] ^ hc0[i];
            hc0[i+1]   = (X[i+4] & Y[i+4]) | (hc0[i] & (X[i+4] ^ Y[i+4]));
            hs1[i]     = X[i+4] ^ Y[i+4] ^ hc1[i];
            hc1[i+1]   = (X[i+4] & Y[i+4]) | (hc1[i] & (X[i+4] ^ Y[i+4]));
        end
        S[7:4] = lc[4] ? hs1 : hs0;
        C8     = lc[4] ? hc1[4] : hc0[4];
    end
endmodule

module addseq_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input logic      clk,
    input logic      rst_n,
    addseq_if.slave  bus
);
    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             in_ready_d;
    logic             out_valid_d;

    logic [W-1:0]     b_eff;
    logic             cin_eff;
    logic             accept;
    logic             last_byte;
    logic             retire;
    logic [7:0]       add_x;
    logic [7:0]       add_y;
    logic [7:0]       add_s;
    logic             add_c8;

`ifdef ADDSEQ_SUB_EN
    // Subtract as a + ~b + 1; cin is overridden.
    always_comb begin
        b_eff   = bus.op ? ~bus.b : bus.b;
        cin_eff = bus.op ? 1'b1 : bus.cin;
    end
`else
    logic unused_op;
    assign unused_op = bus.op;
    assign b_eff     = bus.b;
    assign cin_eff   = bus.cin;
`endif

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign retire    = (state_q == DONE) && bus.out_ready;
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    // Current byte lane of the latched operands.
    assign add_x = a_q[{idx_q, 3'b000} +: 8];
    assign add_y = b_q[{idx_q, 3'b000} +: 8];

    hybridadder8_struct u_add (
        .S  (add_s),
        .C8 (add_c8),
        .X  (add_x),
        .Y  (add_y),
        .C0 (carry_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_byte) state_d = DONE;
            DONE:    if (retire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags follow the next state so they are pure flop outputs.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            IDLE:    in_ready_d  = 1'b1;
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Operand capture and byte-serial accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.a;
                        b_q     <= b_eff;
                        carry_q <= cin_eff;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 3'b000} +: 8] <= add_s;
                    carry_q <= add_c8;
                    if (last_byte) begin
                        // add_s[7] is the final sum MSB being written this edge.
                        ovf_q <= (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_addseq_ctrl.sv
module tb_addseq_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;

    addseq_if #(.NBYTES(4)) bus ();

    addseq_ctrl #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operand pair, waits for the result, then retires it.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic op,
                           output logic [31:0] s, output logic c, output logic o,
                           output int lat, output bit timeout);
        int n;
        timeout = 1'b0;
        bus.a = a; bus.b = b; bus.cin = cin; bus.op = op;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (lat >= 50 || n >= 50) timeout = 1'b1;
        s = bus.sum; c = bus.cout; o = bus.ovf;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passes++;
        checks++; if (bus.sum !== 32'h0) $display("FAIL reset_sum: got %h expected 00000000", bus.sum); else passes++;
        checks++; if ({bus.cout, bus.ovf} !== 2'b00) $display("FAIL reset_cout_ovf: got %b expected 00", {bus.cout, bus.ovf}); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_vectors();
        logic [31:0] s; logic c, o; int lat; bit to;
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat, to);
        checks++; if (to) $display("FAIL wrap_timeout: got timeout expected result"); else passes++;
        checks++; if (lat !== 4) $display("FAIL wrap_latency: got %0d expected 4", lat); else passes++;
        checks++; if ({s, c, o} !== {32'h0000_0000, 1'b1, 1'b0}) $display("FAIL wrap_result: got %h c=%b o=%b expected 00000000 c=1 o=0", s, c, o); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL wrap_in_ready_after: got %b expected 1", bus.in_ready); else passes++;

        run_txn(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat, to);
        checks++; if (to || {s, c, o} !== {32'h8000_0000, 1'b0, 1'b1}) $display("FAIL ovf_result: got %h c=%b o=%b to=%b expected 80000000 c=0 o=1", s, c, o, to); else passes++;

        run_txn(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, s, c, o, lat, to);
        checks++; if (to || {s, c, o} !== {32'h0000_0100, 1'b0, 1'b0}) $display("FAIL carry_chain: got %h c=%b o=%b to=%b expected 00000100 c=0 o=0", s, c, o, to); else passes++;
    endtask

    task automatic test_backpressure();
        int n;
        bus.a = 32'h0000_0012; bus.b = 32'h0000_0034; bus.cin = 1'b0; bus.op = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'h0000_0001; bus.b = 32'h0000_0002;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (n !== 4) $display("FAIL bp_latency: got %0d expected 4", n); else passes++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.sum, bus.cout, bus.ovf, bus.in_ready, bus.out_valid} !== {32'h0000_0046, 1'b0, 1'b0, 1'b0, 1'b1})
                $display("FAIL bp_hold_%0d: got %h c=%b o=%b ir=%b ov=%b expected 00000046 c=0 o=0 ir=0 ov=1",
                         i, bus.sum, bus.cout, bus.ovf, bus.in_ready, bus.out_valid);
            else passes++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL bp_release: got ir=%b ov=%b expected ir=1 ov=0", bus.in_ready, bus.out_valid); else passes++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_accept_next: got ir=%b expected 0", bus.in_ready); else passes++;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (bus.sum !== 32'h0000_0003) $display("FAIL bp_second_sum: got %h expected 00000003", bus.sum); else passes++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] s; logic c, o; int lat; bit to;
        bus.a = 32'h0101_0101; bus.b = 32'h0101_0101; bus.cin = 1'b0; bus.op = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.sum[7:0] !== 8'h02) $display("FAIL midrun_byte0: got %h expected 02", bus.sum[7:0]); else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.sum, bus.in_ready} !== {1'b0, 32'h0, 1'b1})
            $display("FAIL midrun_reset: got ov=%b sum=%h ir=%b expected ov=0 sum=00000000 ir=1", bus.out_valid, bus.sum, bus.in_ready);
        else passes++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s, c, o, lat, to);
        checks++; if (to || {s, c, o} !== {32'h2345_6789, 1'b0, 1'b0}) $display("FAIL after_reset_sum: got %h c=%b o=%b to=%b expected 23456789 c=0 o=0", s, c, o, to); else passes++;
    endtask

    task automatic test_sub();
        logic [31:0] s; logic c, o; int lat; bit to;
        logic [31:0] exp_s;
`ifdef ADDSEQ_SUB_EN
        exp_s = 32'hFFFF_FFFE;
`else
        exp_s = 32'h0000_000C;
`endif
        run_txn(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, s, c, o, lat, to);
        checks++; if (to || {s, c, o} !== {exp_s, 1'b0, 1'b0}) $display("FAIL op_sub: got %h c=%b o=%b to=%b expected %h c=0 o=0", s, c, o, to, exp_s); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.op = 1'b0;
        test_reset();
        test_add_vectors();
        test_backpressure();
        test_reset_midrun();
        test_sub();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
